sram_1r1w_ext: RTL and testbench
================================

Name: sram_1r1w_ext

Overview:
- Parametrised behavioural 1-write/1-read SRAM.
- Successor to the fixed-geometry mem/data/tag array models: generic depth, width and mask granularity; selectable read latency and read-during-write mode.
- Adds a post-reset zeroing sweep and a registered read-valid flag, so read data is defined after reset.
- Used wherever the cache and scratchpad generators need an SRAM that does not come from a macro library.

Parameters:
- ADDR_WIDTH, 10: address bits; DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 32: word width.
- MASK_GRAN, 8: bits per write-mask lane. DATA_WIDTH % MASK_GRAN must be 0, otherwise elaboration fails. LANES = DATA_WIDTH/MASK_GRAN.
- READ_LATENCY, 1: 1 or 2 cycles from R0_en to R0_valid. Any other value fails elaboration.
- RDW_MODE, 0: same-address read-during-write. 0 = old data, 1 = new data (write-through per lane).

Ports:
- clock  in  1  single clock for both ports.
- reset_n  in  1  synchronous active-low reset; sampled on the clock rising edge.
- init_busy  out  1  high while reset is asserted and during the zeroing sweep.
- W0_en  in  1  write enable.
- W0_addr  in  ADDR_WIDTH  write address.
- W0_data  in  DATA_WIDTH  write data.
- W0_mask  in  LANES  per-lane write enable.
- W0_poison  in  1  parity-error injection; used only with the parity feature.
- R0_en  in  1  read enable.
- R0_addr  in  ADDR_WIDTH  read address.
- R0_data  out  DATA_WIDTH  read data; holds its value between reads.
- R0_valid  out  1  one-cycle pulse when R0_data carries a new read result.
- R0_perr  out  1  parity error, qualified by R0_valid.

Behaviour:
- Reset (reset_n=0 at an edge):
  - FSM enters INIT; sweep counter = 0.
  - init_busy=1, R0_valid=0, R0_data=0, R0_perr=0.
  - The read pipeline is flushed.
- INIT state:
  - Each cycle writes all-zero (with correct parity) to ram[counter], then increments the counter.
  - After writing DEPTH-1 the FSM moves to READY. init_busy deasserts on the first READY cycle, DEPTH cycles after reset release.
  - W0_en and R0_en are ignored; R0_valid stays 0.
- Reset asserted mid-INIT or mid-READY: the FSM returns to INIT and the sweep restarts from 0. Read requests in flight are dropped, with no valid pulse.
- READY, write:
  - W0_en=1: lane i of ram[W0_addr] is updated where W0_mask[i]=1.
  - W0_mask=0 with W0_en=1 is a no-op.
- READY, read with READ_LATENCY=1: R0_en at cycle t gives R0_data and R0_valid at t+1.
- READY, read with READ_LATENCY=2: an additional output register; result at t+2.
- Back-to-back reads are accepted every cycle. Throughput is 1/cycle with no backpressure.
- R0_data changes only on cycles where R0_valid=1.
- Same-address read and write in the same cycle:
  - RDW_MODE=0: the read returns the pre-write word.
  - RDW_MODE=1: masked lanes return W0_data and unmasked lanes return the old data.
- Different addresses in the same cycle are fully independent.
- Address wrap: no wrap logic. Addresses are exactly ADDR_WIDTH bits wide, so every address is in range.

Optional Feature:
- Macro: SRAM_PARITY_EN.
- Defined:
  - Stores one even-parity bit per lane, written together with that lane's data.
  - W0_poison=1 inverts the stored parity of every written lane.
  - On a read, R0_perr=1 in the R0_valid cycle if any lane's parity mismatches.
  - In RDW_MODE=1, parity for bypassed lanes is taken from the incoming write.
  - The INIT sweep writes good parity.
- Undefined: no parity storage; R0_perr tied 0; W0_poison ignored.

Decomposition:
- Package sram_pkg:
  - RDW_OLD=0 and RDW_NEW=1 constants.
  - INIT/READY state encoding.
  - Lane-count and parity helper functions.
  - Elaboration-check macros for the parameter rules.
- Sub-module sram_init_fsm:
  - Owns the reset/INIT/READY state and the ADDR_WIDTH sweep counter.
  - Outputs init_busy, the init write strobe and the init address.
  - The top level muxes the init write onto the write port.

Test Plan:
- Reset then poll (ADDR_WIDTH=4): init_busy=1 for exactly 16 cycles after release. Then a read of addr 0..15 returns 0 with R0_valid one cycle after each R0_en.
- Masked write: write 0xAABBCCDD mask 4'b1111 to addr 5, then 0x11223344 mask 4'b0101. Reading addr 5 returns 0xAA22CC44.
- Read-during-write at addr 3 (old 0x0, write 0xFFFFFFFF mask 4'b0011): RDW_MODE=0 returns 0x00000000; RDW_MODE=1 returns 0x0000FFFF.
- READ_LATENCY=2 streaming reads of addrs 1,2,3 on consecutive cycles: valid pulses at t+2,t+3,t+4 with matching data. R0_data holds the last value afterwards.
- Reset asserted at sweep count 7 with reads in flight: no R0_valid pulse. The sweep restarts and init_busy lasts the full DEPTH cycles again.
- With SRAM_PARITY_EN: write with W0_poison=1 to addr 9 → read gives R0_perr=1 with R0_valid. Rewrite without poison → R0_perr=0.

Source files
------------

// File: rtl/sram_pkg.sv
// sram_pkg: shared constants, state encoding, helpers and parameter checks for sram_1r1w_ext
`define SRAM_CHECK(label, cond, msg) if (!(cond)) begin : label $error(msg); end
package sram_pkg;
  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;
  typedef enum logic {ST_INIT = 1'b0, ST_READY = 1'b1} init_state_e;
  function automatic int lane_count(input int dw, input int gran);
    return dw / gran;
  endfunction
  function automatic logic lane_parity(input logic [63:0] lane);
    return ^lane;
  endfunction
endpackage

// File: rtl/sram_init_fsm.sv
// sram_init_fsm: reset/INIT/READY sequencing and the post-reset zeroing sweep address
module sram_init_fsm
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clock,
  input  logic                  reset_n,
  output logic                  init_busy,
  output logic                  init_we,
  output logic [ADDR_WIDTH-1:0] init_addr
);
  init_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  // sweep one word per cycle; leave INIT after the last address is written
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + ADDR_WIDTH'(1);
      if (&cnt_q) state_d = ST_READY;
    end
  end
  // state and sweep counter, restarted by every reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  assign init_busy = !reset_n || state_q == ST_INIT;
  assign init_we   = reset_n && state_q == ST_INIT;
  assign init_addr = cnt_q;
endmodule

// File: rtl/sram_1r1w_ext.sv
// sram_1r1w_ext: behavioural 1R1W SRAM with masked writes, zeroing sweep and optional lane parity (SRAM_PARITY_EN)
module sram_1r1w_ext
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 32,
  parameter int MASK_GRAN    = 8,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = 0,
  localparam int LANES       = lane_count(DATA_WIDTH, MASK_GRAN),
  localparam int DEPTH       = 2 ** ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  output logic                  init_busy,
  input  logic                  W0_en,
  input  logic [ADDR_WIDTH-1:0] W0_addr,
  input  logic [DATA_WIDTH-1:0] W0_data,
  input  logic [LANES-1:0]      W0_mask,
  input  logic                  W0_poison,
  input  logic                  R0_en,
  input  logic [ADDR_WIDTH-1:0] R0_addr,
  output logic [DATA_WIDTH-1:0] R0_data,
  output logic                  R0_valid,
  output logic                  R0_perr
);
  `SRAM_CHECK(g_chk_gran, DATA_WIDTH % MASK_GRAN == 0, "DATA_WIDTH must be a multiple of MASK_GRAN")
  `SRAM_CHECK(g_chk_lat, READ_LATENCY == 1 || READ_LATENCY == 2, "READ_LATENCY must be 1 or 2")
  `SRAM_CHECK(g_chk_lane, MASK_GRAN <= 64, "MASK_GRAN wider than the parity helper")

  logic                  init_we;
  logic [ADDR_WIDTH-1:0] init_addr;
  logic                  we, re, wpoison, bypass, rd_perr;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata, rd_word;
  logic [LANES-1:0]      wmask;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  v1_q, v1_d, v2_q, v2_d, p1_q, p1_d, p2_q, p2_d;
  logic [DATA_WIDTH-1:0] d1_q, d1_d, d2_q, d2_d;

  sram_init_fsm #(.ADDR_WIDTH(ADDR_WIDTH)) u_init (
    .clock     (clock),
    .reset_n   (reset_n),
    .init_busy (init_busy),
    .init_we   (init_we),
    .init_addr (init_addr)
  );

  // the sweep owns the write port while busy; user ports are ignored then
  always_comb begin
    we     = init_busy ? init_we : W0_en;
    waddr  = init_busy ? init_addr : W0_addr;
    wdata  = init_busy ? '0 : W0_data;
    wmask  = init_busy ? '1 : W0_mask;
    re     = R0_en && !init_busy;
    bypass = RDW_MODE == RDW_NEW && we && waddr == R0_addr;
  end

  // per-lane masked write
  always_ff @(posedge clock) begin
    for (int i = 0; i < LANES; i++)
      if (we && wmask[i]) mem_q[waddr][i*MASK_GRAN +: MASK_GRAN] <= wdata[i*MASK_GRAN +: MASK_GRAN];
  end

  // array read with optional same-address write-through of the written lanes
  always_comb begin
    rd_word = mem_q[R0_addr];
    for (int i = 0; i < LANES; i++)
      if (bypass && wmask[i]) rd_word[i*MASK_GRAN +: MASK_GRAN] = wdata[i*MASK_GRAN +: MASK_GRAN];
  end

`ifdef SRAM_PARITY_EN
  logic [LANES-1:0] par_q [DEPTH];
  logic [LANES-1:0] rd_par;
  assign wpoison = !init_busy && W0_poison;
  // even parity per lane, inverted on poisoned writes
  always_ff @(posedge clock) begin
    for (int i = 0; i < LANES; i++)
      if (we && wmask[i]) par_q[waddr][i] <= lane_parity(64'(wdata[i*MASK_GRAN +: MASK_GRAN])) ^ wpoison;
  end
  // parity follows the same bypass as data, then is checked against the returned lanes
  always_comb begin
    rd_par  = par_q[R0_addr];
    rd_perr = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (bypass && wmask[i]) rd_par[i] = lane_parity(64'(wdata[i*MASK_GRAN +: MASK_GRAN])) ^ wpoison;
      rd_perr = rd_perr | (rd_par[i] ^ lane_parity(64'(rd_word[i*MASK_GRAN +: MASK_GRAN])));
    end
  end
`else
  logic unused_poison;
  assign unused_poison = W0_poison;
  assign wpoison = 1'b0;
  assign rd_perr = wpoison;
`endif

  // two output stages; data and parity load only alongside a valid so they hold between reads
  always_comb begin
    v1_d = re;
    d1_d = re ? rd_word : d1_q;
    p1_d = re ? rd_perr : p1_q;
    v2_d = v1_q;
    d2_d = v1_q ? d1_q : d2_q;
    p2_d = v1_q ? p1_q : p2_q;
  end

  // reset flushes the pipeline and clears the visible result
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      p1_q <= 1'b0;
      p2_q <= 1'b0;
      d1_q <= '0;
      d2_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      p1_q <= p1_d;
      p2_q <= p2_d;
      d1_q <= d1_d;
      d2_q <= d2_d;
    end
  end

  assign R0_valid = READ_LATENCY == 2 ? v2_q : v1_q;
  assign R0_data  = READ_LATENCY == 2 ? d2_q : d1_q;
  assign R0_perr  = R0_valid && (READ_LATENCY == 2 ? p2_q : p1_q);
endmodule

// File: tb/tb_sram_1r1w_ext.sv
// tb_sram_1r1w_ext: directed checks of two configurations (latency 1 / old-data, latency 2 / new-data)
module tb_sram_1r1w_ext;
`ifdef SRAM_PARITY_EN
  localparam logic PAR = 1'b1;
`else
  localparam logic PAR = 1'b0;
`endif
  logic        clock = 1'b0;
  logic        reset_n, w_en, w_poison, r_en;
  logic [3:0]  w_addr, r_addr, w_mask;
  logic [31:0] w_data;
  logic        busy0, busy1, v0, v1, pe0, pe1;
  logic [31:0] d0, d1;
  int          total = 0;
  int          bad = 0;
  int          n;
  logic        any_v;

  always #5 clock = ~clock;

  sram_1r1w_ext #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .MASK_GRAN(8), .READ_LATENCY(1), .RDW_MODE(0)) u_old (
    .clock(clock), .reset_n(reset_n), .init_busy(busy0),
    .W0_en(w_en), .W0_addr(w_addr), .W0_data(w_data), .W0_mask(w_mask), .W0_poison(w_poison),
    .R0_en(r_en), .R0_addr(r_addr), .R0_data(d0), .R0_valid(v0), .R0_perr(pe0)
  );

  sram_1r1w_ext #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .MASK_GRAN(8), .READ_LATENCY(2), .RDW_MODE(1)) u_new (
    .clock(clock), .reset_n(reset_n), .init_busy(busy1),
    .W0_en(w_en), .W0_addr(w_addr), .W0_data(w_data), .W0_mask(w_mask), .W0_poison(w_poison),
    .R0_en(r_en), .R0_addr(r_addr), .R0_data(d1), .R0_valid(v1), .R0_perr(pe1)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m, input logic p);
    w_en = 1'b1; w_addr = a; w_data = d; w_mask = m; w_poison = p;
    tick;
    w_en = 1'b0; w_poison = 1'b0;
  endtask

  task automatic count_busy;
    n = 0;
    any_v = 1'b0;
    while (busy0 && n < 40) begin
      tick;
      n++;
      any_v = any_v | v0 | v1;
    end
  endtask

  initial begin
    reset_n = 1'b0; w_en = 1'b0; w_poison = 1'b0; r_en = 1'b0;
    w_addr = '0; r_addr = '0; w_mask = '0; w_data = '0;
    tick; tick; tick;
    check("rst_busy", busy0, 1);
    check("rst_valid", v0, 0);
    check("rst_data", d0, 0);
    check("rst_perr", pe0, 0);
    reset_n = 1'b1;
    count_busy;
    check("init_cycles", n, 16);
    check("init_busy1", busy1, 0);
    for (int a = 0; a < 16; a++) begin
      r_en = 1'b1; r_addr = 4'(a);
      tick;
      check("zero_valid", v0, 1);
      check("zero_data", d0, 0);
    end
    r_en = 1'b0;
    tick;
    check("zero_tail_v1", v1, 1);
    check("zero_tail_d1", d1, 0);
    check("idle_valid", v0, 0);
    wr(4'd5, 32'hAABBCCDD, 4'b1111, 1'b0);
    wr(4'd5, 32'h11223344, 4'b0101, 1'b0);
    r_en = 1'b1; r_addr = 4'd5;
    tick;
    r_en = 1'b0;
    check("mask_v0", v0, 1);
    check("mask_d0", d0, 32'hAA22CC44);
    check("mask_v1_early", v1, 0);
    tick;
    check("mask_v1", v1, 1);
    check("mask_d1", d1, 32'hAA22CC44);
    w_en = 1'b1; w_addr = 4'd3; w_data = 32'hFFFFFFFF; w_mask = 4'b0011;
    r_en = 1'b1; r_addr = 4'd3;
    tick;
    w_en = 1'b0; r_en = 1'b0;
    check("rdw_old", d0, 32'h00000000);
    check("rdw_old_v", v0, 1);
    tick;
    check("rdw_new", d1, 32'h0000FFFF);
    check("rdw_new_v", v1, 1);
    wr(4'd3, 32'h12345678, 4'b0000, 1'b0);
    wr(4'd1, 32'h00000101, 4'b1111, 1'b0);
    wr(4'd2, 32'h00000202, 4'b1111, 1'b0);
    r_en = 1'b1; r_addr = 4'd3;
    tick;
    check("nomask_d0", d0, 32'h0000FFFF);
    r_addr = 4'd1;
    tick;
    r_addr = 4'd2;
    tick;
    check("lat2_a1_v", v1, 1);
    check("lat2_a1_d", d1, 32'h00000101);
    r_addr = 4'd3;
    tick;
    r_en = 1'b0;
    check("lat2_a2_v", v1, 1);
    check("lat2_a2_d", d1, 32'h00000202);
    tick;
    check("lat2_a3_v", v1, 1);
    check("lat2_a3_d", d1, 32'h0000FFFF);
    tick;
    check("lat2_idle_v", v1, 0);
    check("lat2_hold_d", d1, 32'h0000FFFF);
    r_en = 1'b1; r_addr = 4'd5;
    tick;
    reset_n = 1'b0; r_en = 1'b0;
    tick;
    check("flush_v1", v1, 0);
    check("flush_d1", d1, 0);
    check("flush_busy", busy1, 1);
    reset_n = 1'b1;
    for (int i = 0; i < 7; i++) tick;
    check("mid_busy", busy0, 1);
    reset_n = 1'b0; r_en = 1'b1; r_addr = 4'd5;
    tick;
    check("mid_rst_v0", v0, 0);
    reset_n = 1'b1;
    count_busy;
    r_en = 1'b0;
    check("restart_cycles", n, 16);
    check("restart_novalid", any_v, 0);
    r_en = 1'b1; r_addr = 4'd5;
    tick;
    r_en = 1'b0;
    check("swept_v0", v0, 1);
    check("swept_d0", d0, 0);
    wr(4'd9, 32'h00000F01, 4'b1111, 1'b1);
    r_en = 1'b1; r_addr = 4'd9;
    tick;
    r_en = 1'b0;
    check("poison_v0", v0, 1);
    check("poison_d0", d0, 32'h00000F01);
    check("poison_pe0", pe0, 32'(PAR));
    tick;
    check("poison_pe1", pe1, 32'(PAR));
    wr(4'd9, 32'h00000F01, 4'b1111, 1'b0);
    r_en = 1'b1; r_addr = 4'd9;
    tick;
    r_en = 1'b0;
    check("clean_pe0", pe0, 0);
    tick;
    check("clean_pe1", pe1, 0);
    check("clean_v1", v1, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
